rob_multi_cdb: RTL

// Parametrised reorder buffer between dispatch and architectural regfile commit.

---
 rtl/rob_multi_cdb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rob_multi_cdb.sv
// Reorder buffer: in-order allocation, out-of-order completion from NUM_CDB result buses,
// in-order single retire per cycle, full flush on a retiring mispredicted branch.
module rob_multi_cdb #(
    parameter int DEPTH   = 32,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int NUM_CDB = 2,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [4:0]               enq_rd_addr,
    input  logic                     enq_is_branch,
    output logic [IDX_W-1:0]         enq_idx,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_rob_idx,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  logic [NUM_CDB-1:0]       cdb_mispredict,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_target,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [4:0]               commit_rd_addr,
    output logic [XLEN-1:0]          commit_data,
    output logic [IDX_W-1:0]         commit_idx,
    output logic                     flush_o,
    output logic [XLEN-1:0]          flush_pc,
    output logic [IDX_W:0]           count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    logic [IDX_W:0]   r_head;
    logic [IDX_W:0]   r_tail;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_br;
    logic [DEPTH-1:0] r_mp;
    logic [4:0]       r_rd     [DEPTH];
    logic [XLEN-1:0]  r_data   [DEPTH];
    logic [XLEN-1:0]  r_target [DEPTH];

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_commit_fire;
    logic             w_flush;
    logic             w_enq_fire;

    logic [IDX_W-1:0] w_cdb_idx  [NUM_CDB];
    logic [XLEN-1:0]  w_cdb_data [NUM_CDB];
    logic [XLEN-1:0]  w_cdb_tgt  [NUM_CDB];

    logic [DEPTH-1:0] w_hit;
    logic [DEPTH-1:0] w_hit_mp;
    logic [XLEN-1:0]  w_hit_data [DEPTH];
    logic [XLEN-1:0]  w_hit_tgt  [DEPTH];

    for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_port
        assign w_cdb_idx[gi]  = cdb_rob_idx[gi*IDX_W +: IDX_W];
        assign w_cdb_data[gi] = cdb_data[gi*XLEN +: XLEN];
        assign w_cdb_tgt[gi]  = cdb_target[gi*XLEN +: XLEN];
    end

    assign w_head_idx    = r_head[IDX_W-1:0];
    assign w_tail_idx    = r_tail[IDX_W-1:0];
    assign w_empty       = (r_head == r_tail);
    assign w_full        = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_commit_fire = commit_valid && commit_ready;
    assign w_flush       = w_commit_fire && r_mp[w_head_idx];
    assign w_enq_fire    = enq_valid && enq_ready;

    assign enq_ready      = !w_full && !w_flush;
    assign enq_idx        = w_tail_idx;
    assign commit_valid   = !w_empty && r_done[w_head_idx];
    assign commit_rd_addr = r_rd[w_head_idx];
    assign commit_data    = r_data[w_head_idx];
    assign commit_idx     = w_head_idx;
    assign flush_o        = w_flush;
    assign flush_pc       = r_target[w_head_idx];
    assign count_o        = r_tail - r_head;
    assign full_o         = w_full;
    assign empty_o        = w_empty;

    // Per-entry port decode; iterating ports upward lets the highest port win a collision.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_hit[e]      = 1'b0;
            w_hit_mp[e]   = 1'b0;
            w_hit_data[e] = '0;
            w_hit_tgt[e]  = '0;
            for (int p = 0; p < NUM_CDB; p++) begin
                if (cdb_valid[p] && (w_cdb_idx[p] == IDX_W'(e))) begin
                    w_hit[e]      = 1'b1;
                    w_hit_mp[e]   = cdb_mispredict[p];
                    w_hit_data[e] = w_cdb_data[p];
                    w_hit_tgt[e]  = w_cdb_tgt[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_mp    <= '0;
        end else if (w_flush) begin
            // Everything younger than the branch is squashed, including this cycle's traffic.
            r_head  <= r_head + 1'b1;
            r_tail  <= r_head + 1'b1;
            r_valid <= '0;
            r_done  <= '0;
            r_mp    <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_enq_fire && (w_tail_idx == IDX_W'(e))) begin
                    r_valid[e] <= 1'b1;
                    r_done[e]  <= 1'b0;
                    r_mp[e]    <= 1'b0;
                    r_br[e]    <= enq_is_branch;
                    r_rd[e]    <= enq_rd_addr;
                end else if (w_commit_fire && (w_head_idx == IDX_W'(e))) begin
                    r_valid[e] <= 1'b0;
                end else if (w_hit[e] && r_valid[e] && !r_done[e]) begin
                    r_done[e]     <= 1'b1;
                    r_mp[e]       <= r_br[e] && w_hit_mp[e];
                    r_data[e]     <= w_hit_data[e];
                    r_target[e]   <= w_hit_tgt[e];
                end
            end
            if (w_enq_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_commit_fire) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

endmodule
